s_machine_exec_unit: RTL

Multi-cycle execute unit for the S-Machine CPU, and the responder end of the control state machine's start/done handshake. The controller raises `start` and holds it until `done` falls, then waits for `done` to rise. This block latches an opcode and two operands on an accepted `start`, runs a 1- to WIDTH-cycle operation, and publishes the result and flags as `done` returns high. It sits between the controller and the register file / writeback path.

---
 rtl/s_machine_exec_unit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/s_machine_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | s_machine_exec_unit : multi-cycle ALU / shifter / multiplier responding to  |
// |   the controller's start/done handshake. Optional MUL datapath: EXEC_MUL_EN |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module s_machine_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             err
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SHL = 3'b101;
    localparam logic [2:0] c_OP_SHR = 3'b110;
    localparam logic [2:0] c_OP_MUL = 3'b111;

    // IDLE is encoded as 1 so that done is the state flop itself.
    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_IDLE = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_accept;
    logic            w_finish;

    logic [2:0]      r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_load;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_res_lo;
    logic [WIDTH-1:0] w_res_hi;
    logic             w_carry;
    logic             w_err;

`ifdef EXEC_MUL_EN
    // {partial product high, remaining multiplier bits}, shifted right each cycle.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
`endif

    assign done = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                    w_accept     = 1'b1;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_state_next = S_IDLE;
                    w_finish     = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_load = CW'(1);
        case (op)
            c_OP_SHL, c_OP_SHR: begin
                if (b[SW-1:0] != '0) begin
                    w_cnt_load = CW'(b[SW-1:0]);
                end
            end
`ifdef EXEC_MUL_EN
            c_OP_MUL: w_cnt_load = CW'(WIDTH);
`endif
            default: w_cnt_load = CW'(1);
        endcase
    end

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    // Shift amount zero passes the operand through unchanged.
    always_comb begin
        w_shift_next = r_a;
        if (r_b[SW-1:0] != '0) begin
            if (r_op == c_OP_SHL) begin
                w_shift_next = {r_a[WIDTH-2:0], 1'b0};
            end else begin
                w_shift_next = {1'b0, r_a[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        w_res_lo = '0;
        w_res_hi = '0;
        w_carry  = 1'b0;
        w_err    = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_res_lo = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_res_lo = w_diff[WIDTH-1:0];
                w_carry  = w_diff[WIDTH];
            end
            c_OP_AND: w_res_lo = r_a & r_b;
            c_OP_OR:  w_res_lo = r_a | r_b;
            c_OP_XOR: w_res_lo = r_a ^ r_b;
            c_OP_SHL, c_OP_SHR: w_res_lo = w_shift_next;
            c_OP_MUL: begin
`ifdef EXEC_MUL_EN
                w_res_lo = w_acc_next[WIDTH-1:0];
                w_res_hi = w_acc_next[2*WIDTH-1:WIDTH];
                w_carry  = (w_acc_next[2*WIDTH-1:WIDTH] != '0);
`else
                w_err    = 1'b1;
`endif
            end
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
`ifdef EXEC_MUL_EN
            r_acc     <= '0;
`endif
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b1;
            carry     <= 1'b0;
            err       <= 1'b0;
        end else if (w_accept) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= w_cnt_load;
`ifdef EXEC_MUL_EN
            r_acc <= {{WIDTH{1'b0}}, b};
`endif
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_op == c_OP_SHL || r_op == c_OP_SHR) begin
                r_a <= w_shift_next;
            end
`ifdef EXEC_MUL_EN
            if (r_op == c_OP_MUL) begin
                r_acc <= w_acc_next;
            end
`endif
            if (w_finish) begin
                result    <= w_res_lo;
                result_hi <= w_res_hi;
                zero      <= (w_res_lo == '0);
                carry     <= w_carry;
                err       <= w_err;
            end
        end
    end

endmodule
`default_nettype wire
